mem_arbiter: RTL

- Shares one slow memory port between the I-cache and D-cache refill/write-back interfaces of CHIP.
- Sits between the two cache miss ports and a single slow_memory instance.
- Grants one requester per transaction, holds the grant until mem_ready, then forces a one-cycle release gap before the next grant.
- Default policy is fixed priority (D over I); round-robin is a compile option.

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache miss-port arbiter in front of one slow memory port.
// Fixed D-over-I priority by default; define ARB_RR_EN for round-robin tie-breaking.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_read,
    input  logic              I_write,
    input  logic [ADDR_W-1:0] I_addr,
    input  logic [DATA_W-1:0] I_wdata,
    output logic [DATA_W-1:0] I_rdata,
    output logic              I_ready,
    input  logic              D_read,
    input  logic              D_write,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic [DATA_W-1:0] D_wdata,
    output logic [DATA_W-1:0] D_rdata,
    output logic              D_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2,
        REL   = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   req_i, req_d;

    assign req_i = I_read | I_write;
    assign req_d = D_read | D_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ARB_RR_EN
    // last_d_q = 1 when D was the most recent owner; reset points at I so the first tie goes to D
    logic last_d_q, last_d_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        last_d_d = last_d_q;
        if (state_q == IDLE && state_d == OWN_D) begin
            last_d_d = 1'b1;
        end else if (state_q == IDLE && state_d == OWN_I) begin
            last_d_d = 1'b0;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef ARB_RR_EN
                if (req_d && req_i) begin
                    state_d = last_d_q ? OWN_I : OWN_D;
                end else if (req_d) begin
                    state_d = OWN_D;
                end else if (req_i) begin
                    state_d = OWN_I;
                end
`else
                if (req_d) begin
                    state_d = OWN_D;
                end else if (req_i) begin
                    state_d = OWN_I;
                end
`endif
            end
            OWN_I, OWN_D: begin
                if (mem_ready) begin
                    state_d = REL;
                end
            end
            REL:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The owner's request is passed straight through; a withdrawn request simply forwards zeros
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        I_ready   = 1'b0;
        D_ready   = 1'b0;
        case (state_q)
            OWN_I: begin
                mem_read  = I_read;
                mem_write = I_write;
                mem_addr  = I_addr;
                mem_wdata = I_wdata;
                I_ready   = mem_ready;
            end
            OWN_D: begin
                mem_read  = D_read;
                mem_write = D_write;
                mem_addr  = D_addr;
                mem_wdata = D_wdata;
                D_ready   = mem_ready;
            end
            default: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

    assign I_rdata = mem_rdata;
    assign D_rdata = mem_rdata;
    assign busy    = (state_q != IDLE);

endmodule
